// File: rtl/aes_stream_frontend.sv
// Byte-stream front end for an AES-128 core: collects key and plaintext bytes,
// starts the core, waits for completion (with timeout) and drains the result bytewise.
module aes_stream_frontend #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         load,
  output logic [127:0] key,
  output logic [127:0] plaintext,
  input  logic         done,
  input  logic [127:0] cyphertext,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         timeout_err
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RECV, START, WAIT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [4:0]      byte_cnt;
  logic [3:0]      out_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [127:0]    sreg;
  logic            armed;
  logic            accept, xfer, capture, expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RECV;
    else          state <= state_nxt;
  end

  // wait_cnt==0 marks the first WAIT cycle, where a stale done is masked
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    xfer      = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      RECV: begin
        busy     = 1'b0;
        in_ready = armed;
        accept   = armed && in_valid;
        if (accept && byte_cnt == 5'd31) state_nxt = START;
      end
      START: begin
        load      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt != '0 && done) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = RECV;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        xfer      = out_ready;
        if (out_ready && out_cnt == 4'd15) state_nxt = RECV;
      end
      default: state_nxt = RECV;
    endcase
  end

  // armed holds in_ready low until the first clock edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed       <= 1'b0;
      byte_cnt    <= '0;
      out_cnt     <= '0;
      wait_cnt    <= '0;
      key         <= '0;
      plaintext   <= '0;
      sreg        <= '0;
      timeout_err <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        byte_cnt <= byte_cnt + 5'd1;
        if (!byte_cnt[4]) key       <= {key[119:0], in_data};
        else              plaintext <= {plaintext[119:0], in_data};
      end
      if (state == START) begin
        timeout_err <= 1'b0;
        wait_cnt    <= '0;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (expire) timeout_err <= 1'b1;
      if (capture) begin
        sreg <= cyphertext;
      end else if (xfer) begin
        sreg    <= {sreg[119:0], 8'h00};
        out_cnt <= out_cnt + 4'd1;
      end
    end
  end

  assign out_data = sreg[127:120];

endmodule

// File: tb/tb_aes_stream_frontend.sv
// Directed bench for aes_stream_frontend with a behavioural AES core stand-in
// that returns the FIPS-197 result only when the expected key/plaintext are presented.
module tb_aes_stream_frontend;

  localparam logic [127:0] K0    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BOGUS = {16{8'hDE}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_ready;
  logic         load;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done = 1'b0;
  logic [127:0] cyphertext = '0;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  int load_pulses = 0;
  int ov_cycles = 0;

  bit core_stale = 1'b0;
  bit core_hang  = 1'b0;
  int core_lat   = 4;
  int lat_cnt    = 0;
  bit active     = 1'b0;

  aes_stream_frontend #(.TIMEOUT(31)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load       (load),
    .key        (key),
    .plaintext  (plaintext),
    .done       (done),
    .cyphertext (cyphertext),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Core stand-in: done is a level that stays high until the next load
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      active  <= 1'b0;
      lat_cnt <= 0;
    end else if (load) begin
      active     <= 1'b1;
      lat_cnt    <= 0;
      done       <= core_stale;
      cyphertext <= BOGUS;
    end else if (active) begin
      if (core_stale && lat_cnt == 0) done <= 1'b0;
      if (!core_hang && lat_cnt == core_lat) begin
        done       <= 1'b1;
        cyphertext <= (key == K0 && plaintext == P0) ? EXP : (key ^ plaintext);
        active     <= 1'b0;
      end
      lat_cnt <= lat_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (load) load_pulses++;
    if (out_valid) ov_cycles++;
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input bit rnd);
    logic [255:0] blk;
    blk = {K0, P0};
    for (int i = 0; i < 32; i++) send_byte(blk[255-8*i -: 8], rnd);
  endtask

  task automatic recv_block(input bit stall, input logic [127:0] exp);
    logic [7:0] rx [16];
    logic [7:0] held = '0;
    int got = 0;
    int cyc = 0;
    int hold = 0;
    while (got < 16 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stall && got == 8 && hold < 7) begin
        out_ready = 1'b0;
        if (hold == 0) held = out_data;
        else begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            errors++;
            $display("FAIL drain_hold: out_valid=%b out_data=%h required 1/%h", out_valid, out_data, held);
          end
        end
        hold++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          rx[got] = out_data;
          got++;
          if (got == 16) in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL drain_count: got %0d bytes required 16", got);
    end
    for (int k = 0; k < got; k++) begin
      checks++;
      if (rx[k] !== exp[127-8*k -: 8]) begin
        errors++;
        $display("FAIL out_byte%0d: got %h required %h", k, rx[k], exp[127-8*k -: 8]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: out_valid=%b busy=%b in_ready=%b required 0/0/1", out_valid, busy, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || load !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b load=%b out_valid=%b busy=%b timeout_err=%b required all 0",
               in_ready, load, out_valid, busy, timeout_err);
    end
    checks++;
    if (key !== '0 || plaintext !== '0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: key=%h plaintext=%h out_data=%h required 0", key, plaintext, out_data);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge: in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic;
    int lp0;
    lp0 = load_pulses;
    send_block(1'b0);
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL load_latency: load=%b required 1", load);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ctrl: in_ready=%b busy=%b required 0/1", in_ready, busy);
    end
    checks++;
    if (key !== K0) begin
      errors++;
      $display("FAIL key: got %h required %h", key, K0);
    end
    checks++;
    if (plaintext !== P0) begin
      errors++;
      $display("FAIL plaintext: got %h required %h", plaintext, P0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (load !== 1'b0) begin
      errors++;
      $display("FAIL load_width: load=%b required 0", load);
    end
    recv_block(1'b0, EXP);
    checks++;
    if (load_pulses - lp0 != 1) begin
      errors++;
      $display("FAIL load_count: got %0d required 1", load_pulses - lp0);
    end
  endtask

  task automatic test_stale_done;
    core_stale = 1'b1;
    send_block(1'b0);
    recv_block(1'b0, EXP);
    core_stale = 1'b0;
  endtask

  task automatic test_backpressure;
    send_block(1'b1);
    checks++;
    if (key !== K0 || plaintext !== P0) begin
      errors++;
      $display("FAIL rand_input: key=%h plaintext=%h required %h/%h", key, plaintext, K0, P0);
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    recv_block(1'b1, EXP);
  endtask

  task automatic test_timeout;
    int ov0;
    ov0 = ov_cycles;
    core_hang = 1'b1;
    send_block(1'b0);
    repeat (31) @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: timeout_err=%b busy=%b required 0/1", timeout_err, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set: timeout_err=%b busy=%b in_ready=%b required 1/0/1", timeout_err, busy, in_ready);
    end
    checks++;
    if (ov_cycles != ov0) begin
      errors++;
      $display("FAIL timeout_no_output: out_valid cycles %0d required 0", ov_cycles - ov0);
    end
    core_hang = 1'b0;
  endtask

  task automatic test_timeout_clear;
    send_block(1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout_err=%b required 0", timeout_err);
    end
    recv_block(1'b0, EXP);
  endtask

  task automatic test_mid_reset;
    logic [255:0] blk;
    blk = {K0, P0};
    for (int i = 0; i < 20; i++) send_byte(blk[255-8*i -: 8], 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (key !== '0 || plaintext !== '0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_data: key=%h plaintext=%h out_data=%h required 0", key, plaintext, out_data);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || load !== 1'b0 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: in_ready=%b busy=%b load=%b out_valid=%b timeout_err=%b required all 0",
               in_ready, busy, load, out_valid, timeout_err);
    end
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release: in_ready=%b required 1", in_ready);
    end
    send_block(1'b0);
    checks++;
    if (key !== K0 || plaintext !== P0) begin
      errors++;
      $display("FAIL midreset_block: key=%h plaintext=%h required %h/%h", key, plaintext, K0, P0);
    end
    recv_block(1'b0, EXP);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stale_done();
    test_backpressure();
    test_timeout();
    test_timeout_clear();
    test_timeout();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_stream_frontend.md
AES_STREAM_FRONTEND -- requirements
Module: aes_stream_frontend

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31, giving the maximum cycles spent waiting for done before aborting.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, inbound byte available.
REQ-005 SHALL have port in_data, input, 8, inbound byte.
REQ-006 SHALL have port in_ready, output, 1, frontend accepts a byte this cycle.
REQ-007 SHALL have port load, output, 1, start strobe to the AES core.
REQ-008 SHALL have port key, output, 128, key to the AES core.
REQ-009 SHALL have port plaintext, output, 128, plaintext to the AES core.
REQ-010 SHALL have port done, input, 1, AES core completion flag (level).
REQ-011 SHALL have port cyphertext, input, 128, AES core result.
REQ-012 SHALL have port out_valid, output, 1, outbound byte available.
REQ-013 SHALL have port out_data, output, 8, outbound byte.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts the outbound byte.
REQ-015 SHALL have port busy, output, 1, high in every state except RECV.
REQ-016 SHALL have port timeout_err, output, 1, sticky flag set when done is not seen within TIMEOUT.

Function
REQ-017 SHALL implement FSM states RECV, START, WAIT, DRAIN; reset state is RECV.
REQ-018 In RECV, in_ready SHALL be 1, and a byte SHALL be accepted on any cycle with in_valid=1.
REQ-019 A 5-bit byte counter SHALL count accepted bytes from 0 to 31.
- Bytes 0-15 fill key MSB-first: byte 0 goes to key[127:120] and byte 15 to key[7:0].
- Bytes 16-31 fill plaintext in the same order.
REQ-020 On acceptance of byte 31, the FSM SHALL go to START and the counter SHALL wrap to 0.
REQ-021 In START, load SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT; load SHALL be 0 in all other states.
REQ-022 In START, timeout_err SHALL clear to 0.
REQ-023 key and plaintext SHALL change only on accepted bytes in RECV, so they are stable from START through WAIT.
REQ-024 In WAIT, done SHALL be ignored on the first cycle, which masks any stale done from the previous operation.
REQ-025 From the second WAIT cycle, done=1 SHALL latch cyphertext into a 128-bit output shift register, and the FSM SHALL go to DRAIN.
REQ-026 A wait counter SHALL increment each WAIT cycle.
- If it reaches TIMEOUT without done, timeout_err SHALL be set to 1 and the FSM SHALL return to RECV.
- In that case no output bytes are produced.
REQ-027 In DRAIN, out_valid SHALL be 1 and out_data SHALL be the shift register [127:120].
- Each cycle with out_valid=1 and out_ready=1, the register SHALL shift left 8 bits.
REQ-028 After the 16th transferred byte, the FSM SHALL return to RECV and out_valid SHALL drop in the following cycle.
REQ-029 out_data SHALL hold its value while out_valid=1 and out_ready=0; there is no limit on backpressure duration.
REQ-030 in_ready SHALL be 0 outside RECV, and in_valid SHALL be ignored there; no byte is buffered.
REQ-031 The frontend SHALL be fully serialized: input of the next block cannot overlap DRAIN.
REQ-032 Latency from acceptance of byte 31 to load=1 SHALL be exactly 1 cycle.

Reset
REQ-033 reset_n=0 SHALL act immediately regardless of clk and SHALL discard any partial transfer. While reset is asserted:
- FSM = RECV, and all counters = 0.
- key = 0 and plaintext = 0.
- The output shift register = 0.
- in_ready = 0, load = 0, out_valid = 0, busy = 0, timeout_err = 0.
REQ-034 in_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-035 Reset asserted mid-operation in any state SHALL give the same reset values as REQ-033.

Verification
REQ-036 Send 32 bytes (key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff) to a core model. Required response:
- load pulses once.
- key and plaintext match the bytes sent.
- Output is 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, in that order.
REQ-037 Toggle in_valid randomly during input and hold out_ready=0 for 7 cycles mid-drain. Required response: same 16 output bytes, no duplicates or drops.
REQ-038 Keep the core model's done=1 across START and the first WAIT cycle. Required response: that stale done is ignored and capture occurs only on the fresh done.
REQ-039 Hold done=0 after START. Required response: timeout_err=1 after 31 WAIT cycles, FSM back in RECV, out_valid never asserted.
REQ-040 Assert reset_n=0 after 20 input bytes, then release and send a full new 32-byte block. Required response: outputs reach reset values immediately, and the new block encrypts correctly.
